// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter. Core stores are queued in a
// small FIFO and serialised as 8N1 frames (start, 8 data bits LSB first, stop).
// tx_out is registered from the FSM state, so the line lags the state by one
// cycle. Fixed latency from an accepted byte (empty FIFO, IDLE) to the start
// bit on the line is 2 cycles.
module mmio_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          wr_valid_in,
  input  logic [7:0]                    wr_data_in,
  output logic                          wr_ready_out,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW           = AW + 1;

  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          line_active;

  logic          push;
  logic          pop;
  logic          last_tick;
  logic          fifo_empty;

  // Acceptance depends only on the registered count, so a pop in the same
  // cycle never lets a full FIFO take another byte.
  assign wr_ready_out   = (count < DEPTH_C);
  assign fifo_count_out = count;
  assign fifo_empty     = (count == '0);
  assign last_tick      = (timer == LAST_TICK);
  assign push           = wr_valid_in && wr_ready_out;
  assign pop            = !fifo_empty &&
                          ((state == S_IDLE) || ((state == S_STOP) && last_tick));

  // line_active covers the extra cycle the registered line needs to finish
  // the stop bit after the FSM has already returned to IDLE.
  assign busy_out = (state != S_IDLE) || !fifo_empty || line_active;

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_data_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: IDLE -> START -> DATA x8 -> STOP, chaining frames with no gap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (pop) begin
            shift <= fifo_mem[rd_ptr];
            state <= S_START;
          end
        end
        S_START: begin
          if (last_tick) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (last_tick) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_STOP: begin
          if (last_tick) begin
            timer   <= '0;
            bit_idx <= '0;
            if (pop) begin
              shift <= fifo_mem[rd_ptr];
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          timer   <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // Registered serial line driven from the current state; idle and stop are high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_out      <= 1'b1;
      line_active <= 1'b0;
    end else begin
      line_active <= (state != S_IDLE);
      case (state)
        S_START: tx_out <= 1'b0;
        S_DATA:  tx_out <= shift[bit_idx];
        default: tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries, power of two, >= 2.
REQ-004 SHALL have port clk_in, input, 1, system clock, rising-edge active.
REQ-005 SHALL have port rst_in, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid_in, input, 1, core store to the TX data register this cycle.
REQ-007 SHALL have port wr_data_in, input, 8, byte to transmit.
REQ-008 SHALL have port wr_ready_out, output, 1, FIFO can accept a byte.
REQ-009 SHALL have port tx_out, output, 1, serial line, idle high.
REQ-010 SHALL have port busy_out, output, 1, frame in progress or FIFO non-empty.
REQ-011 SHALL have port fifo_count_out, output, $clog2(FIFO_DEPTH)+1, bytes queued and not yet launched.

Function
REQ-012 SHALL use CLKS_PER_BIT = CLK_HZ/BAUD (integer division): 868 at defaults.
REQ-013 SHALL accept a byte on a rising edge where wr_valid_in && wr_ready_out; wr_valid_in with wr_ready_out low is dropped, with no state change.
REQ-014 SHALL drive wr_ready_out = (fifo_count_out < FIFO_DEPTH), from registered count only; a pop in the same cycle does not make a full FIFO accept.
REQ-015 SHALL on a simultaneous accept and pop leave fifo_count_out unchanged and preserve FIFO order.
REQ-016 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with no data loss at wrap.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_out=1; if FIFO non-empty, pop head into shift register, go to START.
REQ-019 START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-020 DATA: tx_out = shift[bit index], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
REQ-021 STOP: tx_out=1 for CLKS_PER_BIT cycles; then, if the FIFO is non-empty, pop and go directly to START with zero idle cycles; else go to IDLE.
REQ-022 SHALL register tx_out (no combinational path from inputs).
REQ-023 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx_out low from edge N+2 (N+1 count visible, N+1 pop/START, tx_out registered at N+2); the latency SHALL be fixed and documented as 2 cycles.
REQ-024 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles (8680 at defaults).
REQ-025 busy_out SHALL be 1 whenever state != IDLE or fifo_count_out != 0.
REQ-026 The bit timer SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state/bit transition.

Reset
REQ-027 SHALL, on rst_in high, asynchronously set tx_out=1, state=IDLE, FIFO pointers and count to 0, timer and bit index to 0.
REQ-028 Reset outputs: tx_out=1, busy_out=0, fifo_count_out=0, wr_ready_out=1.
REQ-029 Reset mid-frame SHALL abort the frame immediately and discard all queued bytes; no partial frame resumes after release.
REQ-030 The block SHALL ignore wr_valid_in while rst_in is high.

Verification
REQ-031 Single byte: reset, write 0xA5 at edge N -> tx_out low at N+2 for 868 cycles, then bits 1,0,1,0,0,1,0,1 at 868 cycles each, then high; busy_out falls 8680 cycles after tx_out falls.
REQ-032 Back-to-back: write 0x55, then 0x0F on the next cycle -> two frames, the second start bit immediately follows the first stop bit, 17360 cycles total low-to-idle.
REQ-033 Full FIFO: write 10 bytes 0x00..0x09 on consecutive cycles with the FSM busy -> after the first byte is popped, 8 are queued, wr_ready_out=0, later writes dropped; output order 0x00..0x08, 0x09 lost unless retried.
REQ-034 Simultaneous push/pop: FIFO full, write on the cycle the FSM pops at STOP end -> write rejected, count goes 8->7.
REQ-035 Reset mid-frame: assert rst_in during DATA bit 3 of 0xFF with 3 bytes queued -> tx_out=1 in the same cycle, count=0, busy_out=0; no further frames after release.
REQ-036 Pointer wrap: send 20 distinct bytes in bursts of 5 -> the receiver model decodes all 20 in order.
